// File: rtl/pwm_pkg.sv
// Shared definitions for carrier-synchronous PWM controllers.
package pwm_pkg;

  localparam int PWM_RESOLUTION = 10;
  localparam int DUTY_MAX       = 2**PWM_RESOLUTION - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_valley_detect.sv
// Single-cycle valley pulse for a dual-slope carrier: fires on the first
// clock the counter sits at zero, never again until it has left zero.
module pwm_valley_detect
  import pwm_pkg::*;
#(
  parameter int RESOLUTION = PWM_RESOLUTION
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RESOLUTION-1:0] counter_i,
  output logic                  valley_o
);

  logic is_zero;
  logic prev_zero_q;

  assign is_zero  = (counter_i == '0);
  assign valley_o = is_zero && !prev_zero_q;

  // Reset to 1 so a counter already parked at zero does not fire on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_zero_q <= 1'b1;
    end else begin
      prev_zero_q <= is_zero;
    end
  end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Walks the PWM compare value toward a requested target, one step per
// RAMP_DIV carrier valleys, so every carrier period sees a stable compare.
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int RESOLUTION = PWM_RESOLUTION,
  parameter int STEP_W     = 6,
  parameter int RAMP_DIV   = 1,
  parameter int INIT_DUTY  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RESOLUTION-1:0] counter,
  input  logic                  direction,
  input  logic [RESOLUTION-1:0] tgt_duty,
  input  logic [STEP_W-1:0]     tgt_step,
  input  logic                  tgt_valid,
  output logic                  tgt_ready,
  output logic [RESOLUTION-1:0] duty,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);

  state_e                state_q, state_d;
  logic [RESOLUTION-1:0] duty_q, duty_d;
  logic [RESOLUTION-1:0] tgt_q, tgt_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [RESOLUTION-1:0] next_duty;
  logic                  valley;

  // One step toward tgt in RESOLUTION+1 bits; clamping to tgt stops overshoot and wrap.
  function automatic logic [RESOLUTION-1:0] step_toward(
    input logic [RESOLUTION-1:0] cur,
    input logic [RESOLUTION-1:0] tgt,
    input logic [STEP_W-1:0]     step
  );
    logic [RESOLUTION:0] cur_x, tgt_x, step_x, nxt_x;
    cur_x  = {1'b0, cur};
    tgt_x  = {1'b0, tgt};
    step_x = (RESOLUTION+1)'(step);
    nxt_x  = tgt_x;
    if (step != '0) begin
      if (tgt_x > cur_x) begin
        if (cur_x + step_x < tgt_x) nxt_x = cur_x + step_x;
      end else if (tgt_x < cur_x) begin
        if (cur_x > tgt_x + step_x) nxt_x = cur_x - step_x;
      end
    end
    return nxt_x[RESOLUTION-1:0];
  endfunction

  pwm_valley_detect #(
    .RESOLUTION(RESOLUTION)
  ) u_valley (
    .clk      (clk),
    .rst      (rst),
    .counter_i(counter),
    .valley_o (valley)
  );

  // The cycle after done is blocked so a new accept never coincides with done.
  assign tgt_ready = (state_q == IDLE) && !done_q;
  assign duty      = duty_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign next_duty = step_toward(duty_q, tgt_q, step_q);

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    tgt_d     = tgt_q;
    step_d    = step_q;
    div_cnt_d = div_cnt_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (tgt_valid && tgt_ready) begin
          tgt_d     = tgt_duty;
          step_d    = tgt_step;
          div_cnt_d = '0;
          if (tgt_duty == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            busy_d  = 1'b1;
          end
        end
      end
      RAMP: begin
        if (valley) begin
          if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            duty_d    = next_duty;
            if (next_duty == tgt_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      duty_q    <= RESOLUTION'(INIT_DUTY);
      div_cnt_q <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      div_cnt_q <= div_cnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
    tgt_q  <= tgt_d;
    step_q <= step_d;
  end

  // The carrier must be heading up right after its valley.
  a_valley_dir: assert property (@(posedge clk) disable iff (rst) valley |=> direction);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench: triangle carrier 0..1023..0 driving two controllers,
// one with RAMP_DIV = 1 and one with RAMP_DIV = 2.
module tb_pwm_duty_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] counter = 10'd0;
  logic       cdir = 1'b1;

  logic [9:0] tgt_duty1, tgt_duty2, duty1, duty2;
  logic [5:0] tgt_step1, tgt_step2;
  logic       tgt_valid1, tgt_valid2, tgt_ready1, tgt_ready2;
  logic       busy1, busy2, done1, done2;

  int checks = 0;
  int errors = 0;
  int down_exp [6] = '{100, 60, 60, 20, 20, 10};
  logic changed;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cdir) begin
      if (counter == 10'd1023) begin
        counter <= 10'd1022;
        cdir    <= 1'b0;
      end else begin
        counter <= counter + 10'd1;
      end
    end else begin
      if (counter == 10'd1) begin
        counter <= 10'd0;
        cdir    <= 1'b1;
      end else begin
        counter <= counter - 10'd1;
      end
    end
  end

  pwm_duty_ramp_ctrl #(.RESOLUTION(10), .STEP_W(6), .RAMP_DIV(1), .INIT_DUTY(0)) u_dut1 (
    .clk(clk), .rst(rst), .counter(counter), .direction(cdir),
    .tgt_duty(tgt_duty1), .tgt_step(tgt_step1), .tgt_valid(tgt_valid1),
    .tgt_ready(tgt_ready1), .duty(duty1), .busy(busy1), .done(done1)
  );

  pwm_duty_ramp_ctrl #(.RESOLUTION(10), .STEP_W(6), .RAMP_DIV(2), .INIT_DUTY(0)) u_dut2 (
    .clk(clk), .rst(rst), .counter(counter), .direction(cdir),
    .tgt_duty(tgt_duty2), .tgt_step(tgt_step2), .tgt_valid(tgt_valid2),
    .tgt_ready(tgt_ready2), .duty(duty2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where the counter equals v (bounded to one period).
  task automatic wait_cnt(input logic [9:0] v);
    int n = 0;
    while (counter != v && n < 2100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_timeout", 32'(n < 2100), 32'd1);
  endtask

  // Valley cycle, then the following cycle where a valley update is visible.
  task automatic step_update();
    wait_cnt(10'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    tgt_valid1 = 1'b0; tgt_duty1 = '0; tgt_step1 = '0;
    tgt_valid2 = 1'b0; tgt_duty2 = '0; tgt_step2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", 32'(duty1), 32'd0);
    chk("rst_ready", 32'(tgt_ready1), 32'd1);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_duty2", 32'(duty2), 32'd0);
    rst = 1'b0;

    changed = 1'b0;
    repeat (2100) begin
      @(negedge clk);
      if (duty1 !== 10'd0 || done1 !== 1'b0) changed = 1'b1;
    end
    chk("idle_hold", 32'(changed), 32'd0);

    // Up ramp on dut1; dut2 jumps to 100 over two valleys.
    tgt_duty1 = 10'd100; tgt_step1 = 6'd16; tgt_valid1 = 1'b1;
    tgt_duty2 = 10'd100; tgt_step2 = 6'd0;  tgt_valid2 = 1'b1;
    @(negedge clk);
    tgt_valid1 = 1'b0; tgt_valid2 = 1'b0;
    chk("up_busy", 32'(busy1), 32'd1);
    chk("up_ready", 32'(tgt_ready1), 32'd0);
    chk("div_busy", 32'(busy2), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      step_update();
      chk("up_duty", 32'(duty1), (k < 7) ? 32'(16 * k) : 32'd100);
      chk("up_done", 32'(done1), 32'(k == 7));
      if (k == 1) chk("div_hold", 32'(duty2), 32'd0);
      if (k == 2) begin
        chk("div_jump", 32'(duty2), 32'd100);
        chk("div_jump_done", 32'(done2), 32'd1);
      end
    end
    @(negedge clk);
    chk("up_busy_drop", 32'(busy1), 32'd0);
    chk("up_done_clr", 32'(done1), 32'd0);
    chk("up_ready_back", 32'(tgt_ready1), 32'd1);

    // Jump with step 0 requested mid-period.
    wait_cnt(10'd500);
    tgt_duty1 = 10'd1023; tgt_step1 = 6'd0; tgt_valid1 = 1'b1;
    @(negedge clk);
    tgt_valid1 = 1'b0;
    wait_cnt(10'd0);
    chk("jump_hold", 32'(duty1), 32'd100);
    @(negedge clk);
    chk("jump_duty", 32'(duty1), 32'd1023);
    chk("jump_done", 32'(done1), 32'd1);
    chk("jump_ready_blk", 32'(tgt_ready1), 32'd0);

    // Equal target completes without a valley.
    @(negedge clk);
    chk("eq_ready", 32'(tgt_ready1), 32'd1);
    tgt_duty1 = 10'd1023; tgt_step1 = 6'd5; tgt_valid1 = 1'b1;
    @(negedge clk);
    tgt_valid1 = 1'b0;
    chk("eq_done", 32'(done1), 32'd1);
    chk("eq_duty", 32'(duty1), 32'd1023);
    chk("eq_busy", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("eq_done_clr", 32'(done1), 32'd0);
    chk("eq_ready_back", 32'(tgt_ready1), 32'd1);

    // Down ramp with divider on dut2.
    tgt_duty2 = 10'd10; tgt_step2 = 6'd40; tgt_valid2 = 1'b1;
    @(negedge clk);
    tgt_valid2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step_update();
      chk("down_duty", 32'(duty2), 32'(down_exp[k]));
      chk("down_done", 32'(done2), 32'(k == 5));
    end

    // Backpressure: a held request waits for tgt_ready.
    tgt_duty1 = 10'd1000; tgt_step1 = 6'd16; tgt_valid1 = 1'b1;
    @(negedge clk);
    tgt_duty1 = 10'd500;
    chk("bp_ready", 32'(tgt_ready1), 32'd0);
    step_update();
    chk("bp_duty1", 32'(duty1), 32'd1007);
    chk("bp_ready1", 32'(tgt_ready1), 32'd0);
    step_update();
    chk("bp_duty2", 32'(duty1), 32'd1000);
    chk("bp_done", 32'(done1), 32'd1);
    chk("bp_ready_done", 32'(tgt_ready1), 32'd0);
    @(negedge clk);
    chk("bp_ready_open", 32'(tgt_ready1), 32'd1);
    chk("bp_busy_idle", 32'(busy1), 32'd0);
    @(negedge clk);
    tgt_valid1 = 1'b0;
    chk("bp_accepted", 32'(busy1), 32'd1);
    chk("bp_ready_ramp", 32'(tgt_ready1), 32'd0);
    step_update();
    chk("bp_duty3", 32'(duty1), 32'd984);

    // Reset in the middle of a ramp.
    wait_cnt(10'd300);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_duty", 32'(duty1), 32'd0);
    chk("mid_rst_done", 32'(done1), 32'd0);
    chk("mid_rst_ready", 32'(tgt_ready1), 32'd1);
    chk("mid_rst_busy", 32'(busy1), 32'd0);
    chk("mid_rst_duty2", 32'(duty2), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
